// File: rtl/reg_dump_reader_pkg.sv
// -----------------------------------------------------------------------------
// reg_dump_reader_pkg
// Shared definitions for the register-file debug dump engine.
//   dump_state_t : FSM state encoding for reg_dump_reader
// -----------------------------------------------------------------------------
package reg_dump_reader_pkg;

  typedef enum logic [1:0] {
    DS_IDLE   = 2'd0,
    DS_FETCH  = 2'd1,
    DS_SEND   = 2'd2,
    DS_FINISH = 2'd3
  } dump_state_t;

endpackage : reg_dump_reader_pkg

// File: rtl/reg_dump_reader.sv
// -----------------------------------------------------------------------------
// reg_dump_reader
// Debug read-out engine: while the core is halted, walks every register of the
// register file through its debug read port, streams each value out over a
// valid/ready handshake and accumulates an XOR checksum of the beats sent.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   Start      in   dump request, sampled only in IDLE
//   Halted     in   core frozen (register file writes inhibited)
//   RdAddr     out  D  register file debug read address (= index)
//   RdData     in   W  combinational read data for RdAddr
//   DumpData   out  W  current beat value
//   DumpAddr   out  D  register index of current beat
//   DumpValid  out  beat available
//   DumpReady  in   sink accepts beat
//   DumpLast   out  high with the final beat
//   Busy       out  high in any state but IDLE
//   Done       out  one-cycle pulse after a complete dump
//   Aborted    out  one-cycle pulse when a dump ends early
//   Checksum   out  W  XOR of all beats sent in the current/last dump
// -----------------------------------------------------------------------------
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic         Halted,
  output logic [D-1:0] RdAddr,
  input  logic [W-1:0] RdData,
  output logic [W-1:0] DumpData,
  output logic [D-1:0] DumpAddr,
  output logic         DumpValid,
  input  logic         DumpReady,
  output logic         DumpLast,
  output logic         Busy,
  output logic         Done,
  output logic         Aborted,
  output logic [W-1:0] Checksum
);

  // All-ones index equals 2**D-1, the final register.
  localparam logic [D-1:0] DUMP_LAST_IDX = {D{1'b1}};

  dump_state_t  r_state;
  logic [D-1:0] r_index;
  logic [W-1:0] r_dump_data;
  logic [D-1:0] r_dump_addr;
  logic         r_valid;
  logic         r_last;
  logic         r_busy;
  logic         r_done;
  logic         r_aborted;
  logic [W-1:0] r_checksum;

  logic         w_handshake;

  assign w_handshake = r_valid & DumpReady;

  // Dump FSM with index counter, beat registers, status pulses and checksum.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= DS_IDLE;
      r_index     <= '0;
      r_dump_data <= '0;
      r_dump_addr <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_checksum  <= '0;
    end else begin
      // Status outputs are single-cycle pulses unless re-armed below.
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        DS_IDLE: begin
          // A request while the core runs is silently dropped.
          if (Start && Halted) begin
            r_index    <= '0;
            r_checksum <= '0;
            r_busy     <= 1'b1;
            r_state    <= DS_FETCH;
          end else begin
            r_state <= DS_IDLE;
          end
        end
        DS_FETCH: begin
          r_dump_data <= RdData;
          r_dump_addr <= r_index;
          r_valid     <= 1'b1;
          r_last      <= (r_index == DUMP_LAST_IDX);
          r_state     <= DS_SEND;
        end
        DS_SEND: begin
          // The presented beat is held until accepted; Halted is only
          // consulted once the beat has gone, so a beat is never withdrawn.
          if (w_handshake) begin
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_checksum <= r_checksum ^ r_dump_data;
            if (r_index == DUMP_LAST_IDX) begin
              r_done  <= 1'b1;
              r_state <= DS_FINISH;
            end else if (!Halted) begin
              r_aborted <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= DS_IDLE;
            end else begin
              r_index <= r_index + D'(1);
              r_state <= DS_FETCH;
            end
          end else begin
            r_state <= DS_SEND;
          end
        end
        DS_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= DS_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= DS_IDLE;
        end
      endcase
    end
  end

  assign RdAddr    = r_index;
  assign DumpData  = r_dump_data;
  assign DumpAddr  = r_dump_addr;
  assign DumpValid = r_valid;
  assign DumpLast  = r_last;
  assign Busy      = r_busy;
  assign Done      = r_done;
  assign Aborted   = r_aborted;
  assign Checksum  = r_checksum;

endmodule : reg_dump_reader

// File: doc/reg_dump_reader.md
# reg_dump_reader

Debug read-out engine for the processor register file. On request it walks every register through a dedicated read port, streams each value out over a valid/ready handshake, and accumulates an XOR checksum. It sits between the register file's debug read port and the test harness/host link. It only reads while the core is halted, so it never races the file's write path.

## Interface
Parameters:
- W, 8, data path width (register width)
- D, 4, register pointer width; 2**D registers are dumped

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  request a dump; sampled only in IDLE
- Halted  in  1  core frozen; register file writes inhibited while high
- RdAddr  out  D  register file debug read address
- RdData  in  W  combinational read data for RdAddr
- DumpData  out  W  current beat value (registered)
- DumpAddr  out  D  register index of current beat
- DumpValid  out  1  beat available
- DumpReady  in  1  sink accepts beat
- DumpLast  out  1  high with the final beat (index 2**D-1)
- Busy  out  1  high in any state but IDLE
- Done  out  1  one-cycle pulse after a complete dump
- Aborted  out  1  one-cycle pulse when a dump ends early
- Checksum  out  W  XOR of all beats sent in the current/last dump

## Operation
- States: IDLE, FETCH, SEND, FINISH.
- IDLE: if Start && Halted, clear index and Checksum, go to FETCH. Start while !Halted is ignored, with no status change.
- FETCH: drive RdAddr = index. Capture RdData into DumpData and index into DumpAddr. Go to SEND.
- SEND: DumpValid=1. DumpData and DumpAddr are held stable until DumpValid && DumpReady.
  - On handshake: Checksum ^= DumpData.
  - If index == 2**D-1, go to FINISH.
  - Else if !Halted, pulse Aborted and go to IDLE.
  - Else index++ and go to FETCH.
- FINISH: Done=1 for one cycle, then go to IDLE. Checksum holds its value until the next accepted Start.
- Abort is checked only at beat boundaries. A beat already presented is never withdrawn, even if Halted falls mid-beat.
- Index counter is D bits wide. The last-beat compare is done before increment, so the counter never wraps mid-dump.
- RdAddr = index in every state; its value outside FETCH is don't-care to the file.
- DumpLast = DumpValid && (DumpAddr == 2**D-1).

## Timing
- Reset (async assert, sync release): state IDLE; index, RdAddr, DumpData, DumpAddr, Checksum = 0; DumpValid, DumpLast, Busy, Done, Aborted = 0.
- Reset mid-dump: all outputs return immediately to their reset values. No Done and no Aborted is issued.
- Start accepted at edge T: FETCH in cycle T+1, first DumpValid in cycle T+2.
- Each beat takes 2 cycles with DumpReady held high. Every cycle DumpReady is low while in SEND adds one cycle.
- Full dump with Ready always high: Start edge to Done pulse = 2·2**D + 1 cycles (33 for D=4).
- Done and Aborted are mutually exclusive and registered. Busy falls in the same cycle IDLE is re-entered.

## Structure
- The definitions package gets:
  - typedef enum logic [1:0] dump_state_t {DS_IDLE, DS_FETCH, DS_SEND, DS_FINISH}
  - localparam DUMP_LAST_IDX, derived as 2**D-1 in the module
- Single module with no sub-modules. The FSM, index counter and checksum register are small enough to stay inline.

## Test plan
- Register file preloaded with r[i]=8'h10+i, Halted=1, Start pulse, DumpReady=1 → 16 beats, DumpAddr 0..15, DumpData 8'h10..8'h1F, DumpLast only on beat 15, Done at cycle 33, Checksum=8'h00.
- Same preload, DumpReady toggling 1,0,1,0 → every beat is held stable while Ready=0, no beats are dropped or duplicated, Done at cycle 33 plus the number of stall cycles.
- Start with Halted=0 → Busy stays 0, no DumpValid, Checksum unchanged.
- Halted falls during beat 5 (before its handshake) → beat 5 still completes with its original data, then Aborted pulses, Busy drops, and no beat 6 is sent.
- Reset_n asserted during beat 9 → all outputs are 0 asynchronously. After release a new Start produces a full dump from index 0.
- r[3]=8'hA5 and all other registers 0 → Checksum=8'hA5 at Done. A second Start clears it before re-accumulating, giving 8'hA5 again.
